seg_display: RTL and testbench
==============================

# seg_display

Four-digit multiplexed seven-segment display driver at the output boundary of the CPU top, consuming the result word the Execute stage produces and the halt indication. It latches a 16-bit value as four hex digits, commits it to the panel only at frame boundaries (no tearing), scans one digit at a time with dead-time blanking, and drives the `SEG`/`SEG_SEL` board pins. A halted CPU is shown by lighting every decimal point.

## Interface
- `DIV`, 50000: clock cycles per digit slot; must satisfy `DIV >= BLANK + 2`.
- `BLANK`, 16: dead-time cycles at the start of each slot with all digits off; `0` is legal.
- `LZB`, 0: `1` enables leading-zero blanking.
- `ACTIVE_LOW`, 1: `1` means segment and select pins are active-low (common anode). `0` inverts both.

- `clk`  in  1  system clock. The single clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `value`  in  16  result word to display.
- `value_valid`  in  1  one-cycle strobe qualifying `value`.
- `halt`  in  1  CPU halt indication. Sampled each cycle.
- `SEG`  out  8  segment pattern, `{dp,g,f,e,d,c,b,a}`.
- `SEG_SEL`  out  4  digit select, one-hot active. Bit 0 is the rightmost digit, `value[3:0]`.
- `frame_done`  out  1  one-cycle pulse at the end of each full 4-digit scan.

## Operation
- **Slot counter.** `cnt` counts `0..DIV-1`. Digit index `idx` advances on `cnt==DIV-1` and wraps `3->0`. That wrap cycle is the frame boundary.
- **Capture.** `value_valid` writes `value` into `shadow` and sets `pending`. When several strobes arrive in one frame, the last one wins.
- **Commit at frame boundary.**
  - If `value_valid` is high in the same cycle, `disp <= value` directly (bypass) and `pending` clears.
  - Otherwise, if `pending` is set, `disp <= shadow` and `pending` clears.
- **Halt.** `halt_l` sets on any cycle with `halt==1`. It is sticky and cleared only by `rst`. While set, `dp` is lit on every driven digit.
- **Per-slot output phases:**
  - BLANK phase (`cnt < BLANK`): all selects inactive, all segments off.
  - DRIVE phase: the select for `idx` is active and the segments show `hex(disp[4*idx+3:4*idx])` plus `dp`.
- **Hex map** (active-high `gfedcba`):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- **Leading-zero blanking.** With `LZB=1`, digit `i>0` is blanked (segments off, dp still shown if `halt_l`) when nibbles `i..3` of `disp` are all zero. Digit 0 is never blanked.
- **Polarity.** With `ACTIVE_LOW=1`, outputs are the bitwise inverse of the active-high patterns. Example: "0" with dp off is `8'hC0`; digit 2 selected is `4'b1011`.

## Timing
- `SEG`, `SEG_SEL` and `frame_done` are registered: each reflects the `cnt`/`idx`/`disp`/`halt_l` state of the previous cycle (1-cycle latency).
- **Reset** forces, asynchronously:
  - state: `cnt=0`, `idx=0`, `disp=0`, `shadow=0`, `pending=0`, `halt_l=0`;
  - outputs: `SEG` and `SEG_SEL` all-inactive (`8'hFF`/`4'hF` when `ACTIVE_LOW`), `frame_done=0`.
- **After reset deassert:** the first slot starts with `cnt=0` and `idx=0`. The first driven output appears `BLANK+1` cycles later.
- **Frame length:** exactly `4*DIV` cycles.
- **`frame_done` pulse:** high for exactly one cycle, the cycle after the wrap `idx 3->0` at `cnt==DIV-1`.
- **`BLANK=0`:** no dead time. A select change between consecutive slots happens in a single cycle.
- **Update latency:**
  - A committed value becomes visible on the next frame's first DRIVE phase.
  - Worst case from `value_valid` to display is about `4*DIV + BLANK + 1` cycles.
- **Reset mid-frame:** any pending value is discarded and the display returns to `0000`.
- **`halt` timing:** `halt` affects `dp` from the next slot-phase output cycle (1-cycle latency). It is not deferred to a frame boundary.

## Test plan
Directed scenarios, with `DIV=8`, `BLANK=2`, `ACTIVE_LOW=1`, `LZB=0` unless stated:
- **Reset:** assert `rst` mid-scan -> `SEG=8'hFF`, `SEG_SEL=4'hF`, `frame_done=0` immediately. After release, the first `SEG_SEL=4'b1110` appears 3 cycles later with `SEG=8'hC0`.
- **Commit:** strobe `value=16'h1A3F` mid-frame -> the current frame still shows `0000`. The next frame shows, in slot order (digits 0..3):
  - digit 0: `SEG=~8'h71`;
  - digit 1: `~8'h4F`;
  - digit 2: `~8'h77`;
  - digit 3: `~8'h06`.
- **Same-cycle and last-wins:**
  - Strobe `16'h0005` and then `16'h0009` within one frame -> the next frame shows `0009`.
  - Strobe `16'h0007` exactly on the wrap cycle -> the frame starting now shows `0007`.
- **Blanking and cadence:** every slot has exactly 2 cycles of `SEG_SEL=4'hF` followed by 6 cycles of one-hot select. `frame_done` pulses once every 32 cycles.
- **Halt:** pulse `halt` for one cycle -> `dp` is lit (`SEG[7]=0`) on all subsequent digits until `rst`. A following `rst` clears it.
- **LZB:** with `LZB=1` and `value=16'h0040` -> digits 3 and 2 show `SEG=8'hFF` while selected, digit 1 shows `~8'h66`, digit 0 shows `~8'h3F`. With `value=0` only digit 0 is lit.

Source files
------------

// File: rtl/seg_display_if.sv
// Bundle between the CPU result/halt sources and the seven-segment driver,
// including the board-facing segment and select pins.
interface seg_display_if;
  logic [15:0] value;
  logic        value_valid;
  logic        halt;
  logic [7:0]  SEG;
  logic [3:0]  SEG_SEL;
  logic        frame_done;

  modport master (output value, value_valid, halt, input SEG, SEG_SEL, frame_done);
  modport slave  (input value, value_valid, halt, output SEG, SEG_SEL, frame_done);
endinterface

// File: rtl/seg_display.sv
// Four-digit multiplexed seven-segment driver: latches a 16-bit word, commits it
// only at frame boundaries, scans digits with dead-time blanking, shows halt on dp.
module seg_display #(
  parameter int DIV        = 50000,
  parameter int BLANK      = 16,
  parameter int LZB        = 0,
  parameter int ACTIVE_LOW = 1
) (
  input  logic          clk,
  input  logic          rst,
  seg_display_if.slave  bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [7:0] SEG_INV = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [3:0] SEL_INV = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   disp;
  logic [15:0]   shadow;
  logic          pending;
  logic          halt_l;

  logic slot_end;
  logic frame_wrap;
  assign slot_end   = (cnt == CW'(DIV - 1));
  assign frame_wrap = slot_end && (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A strobe coinciding with the frame wrap bypasses the shadow register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp    <= 16'h0000;
      shadow  <= 16'h0000;
      pending <= 1'b0;
      halt_l  <= 1'b0;
    end else begin
      if (bus.halt)
        halt_l <= 1'b1;
      if (bus.value_valid)
        shadow <= bus.value;
      if (frame_wrap) begin
        pending <= 1'b0;
        if (bus.value_valid)
          disp <= bus.value;
        else if (pending)
          disp <= shadow;
      end else if (bus.value_valid) begin
        pending <= 1'b1;
      end
    end
  end

  logic in_blank;
  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < CW'(BLANK));
    end
  endgenerate

  // Digit gi is a leading zero when it and every higher nibble are zero.
  logic [3:0] digit_blank;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lzb
      if (LZB != 0 && gi > 0) begin : g_on
        assign digit_blank[gi] = ~|disp[15:4*gi];
      end else begin : g_off
        assign digit_blank[gi] = 1'b0;
      end
    end
  endgenerate

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic [3:0] nib;
  logic [7:0] seg_hi;
  logic [3:0] sel_hi;
  assign nib = disp[{idx, 2'b00} +: 4];

  always_comb begin
    seg_hi = 8'h00;
    sel_hi = 4'h0;
    if (!in_blank) begin
      sel_hi = 4'b0001 << idx;
      seg_hi = {halt_l, digit_blank[idx] ? 7'h00 : hex7(nib)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.SEG        <= SEG_INV;
      bus.SEG_SEL    <= SEL_INV;
      bus.frame_done <= 1'b0;
    end else begin
      bus.SEG        <= seg_hi ^ SEG_INV;
      bus.SEG_SEL    <= sel_hi ^ SEL_INV;
      bus.frame_done <= frame_wrap;
    end
  end
endmodule

// File: tb/tb_seg_display.sv
// Directed bench for seg_display (DIV=8, BLANK=2, active-low): one plain and one
// leading-zero-blanking instance driven in lockstep, checked every cycle.
module tb_seg_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k = 0;
  int   total = 0;
  int   passed = 0;

  seg_display_if bus_a ();
  seg_display_if bus_b ();

  seg_display #(.DIV(8), .BLANK(2), .LZB(0), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .bus(bus_a));
  seg_display #(.DIV(8), .BLANK(2), .LZB(1), .ACTIVE_LOW(1)) dut_lzb (
    .clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  function automatic logic [6:0] hex_ref(input logic [3:0] n);
    case (n)
      4'h0: hex_ref = 7'h3F;  4'h1: hex_ref = 7'h06;  4'h2: hex_ref = 7'h5B;  4'h3: hex_ref = 7'h4F;
      4'h4: hex_ref = 7'h66;  4'h5: hex_ref = 7'h6D;  4'h6: hex_ref = 7'h7D;  4'h7: hex_ref = 7'h07;
      4'h8: hex_ref = 7'h7F;  4'h9: hex_ref = 7'h6F;  4'hA: hex_ref = 7'h77;  4'hB: hex_ref = 7'h7C;
      4'hC: hex_ref = 7'h39;  4'hD: hex_ref = 7'h5E;  4'hE: hex_ref = 7'h79;  default: hex_ref = 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s k=%0d got %h expected %h", tag, k, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Expected outputs after edge k, given the displayed word and dp state.
  task automatic check_out(input string tag, input logic [7:0] seg, input logic [3:0] sel,
                           input logic fd, input logic [15:0] disp, input bit lzb, input bit dp);
    int t, ph, d;
    logic [7:0] e_seg;
    logic [3:0] e_sel;
    logic [15:0] upper;
    logic [3:0] one;
    t = k - 1;
    ph = t % 8;
    d = (t / 8) % 4;
    one = 4'b0001;
    upper = disp >> (4 * d);
    if (ph < 2) begin
      e_seg = 8'hFF;
      e_sel = 4'hF;
    end else begin
      e_sel = ~(one << d);
      if (lzb && d > 0 && upper == 16'h0000)
        e_seg = ~{dp, 7'h00};
      else
        e_seg = ~{dp, hex_ref(upper[3:0])};
    end
    chk({tag, ".SEG"}, seg, e_seg);
    chk({tag, ".SEL"}, {4'h0, sel}, {4'h0, e_sel});
    chk({tag, ".FD"}, {7'h0, fd}, {7'h0, (k % 32 == 0)});
  endtask

  // Asynchronous reset between edges, then the first three cycles after release.
  task automatic reset_and_check();
    #2 rst = 1'b1;
    #1;
    chk("rst_a.SEG", bus_a.SEG, 8'hFF);
    chk("rst_a.SEL", {4'h0, bus_a.SEG_SEL}, 8'h0F);
    chk("rst_a.FD", {7'h0, bus_a.frame_done}, 8'h00);
    chk("rst_b.SEG", bus_b.SEG, 8'hFF);
    chk("rst_b.SEL", {4'h0, bus_b.SEG_SEL}, 8'h0F);
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("post_rst_a", bus_a.SEG, bus_a.SEG_SEL, bus_a.frame_done, 16'h0000, 1'b0, 1'b0);
      check_out("post_rst_b", bus_b.SEG, bus_b.SEG_SEL, bus_b.frame_done, 16'h0000, 1'b1, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] exp_a, exp_b;
    int f;
    bus_a.value = 16'h0000; bus_a.value_valid = 1'b0; bus_a.halt = 1'b0;
    bus_b.value = 16'h0000; bus_b.value_valid = 1'b0; bus_b.halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("boot_a", bus_a.SEG, bus_a.SEG_SEL, bus_a.frame_done, 16'h0000, 1'b0, 1'b0);
    end

    // Mid-scan reset while digit 0 is being driven.
    reset_and_check();

    // Main run: commit, last-wins, wrap bypass, halt.
    while (k < 200) begin
      bus_a.value_valid = 1'b0;
      bus_b.value_valid = 1'b0;
      bus_a.halt = (k == 165);
      bus_b.halt = (k == 165);
      case (k)
        9: begin
          bus_a.value = 16'h1A3F; bus_a.value_valid = 1'b1;
          bus_b.value = 16'h0040; bus_b.value_valid = 1'b1;
        end
        69: begin
          bus_a.value = 16'h0005; bus_a.value_valid = 1'b1;
          bus_b.value = 16'h0000; bus_b.value_valid = 1'b1;
        end
        79: begin
          bus_a.value = 16'h0009; bus_a.value_valid = 1'b1;
        end
        127: begin
          bus_a.value = 16'h0007; bus_a.value_valid = 1'b1;
        end
        default: ;
      endcase
      tick();
      f = (k - 1) / 32;
      case (f)
        0: exp_a = 16'h0000;
        1, 2: exp_a = 16'h1A3F;
        3: exp_a = 16'h0009;
        default: exp_a = 16'h0007;
      endcase
      exp_b = (f == 1 || f == 2) ? 16'h0040 : 16'h0000;
      check_out("run_a", bus_a.SEG, bus_a.SEG_SEL, bus_a.frame_done, exp_a, 1'b0, k >= 167);
      check_out("run_b", bus_b.SEG, bus_b.SEG_SEL, bus_b.frame_done, exp_b, 1'b1, k >= 167);
    end
    bus_a.halt = 1'b0;
    bus_b.halt = 1'b0;

    // Reset clears the sticky halt and the displayed value.
    reset_and_check();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
